mmio_console: RTL
=================

Name: mmio_console

Overview:
- Device end of the test-processor MMIO output protocol; sits on data write port 1 beside the memory model.
- Stores to 0x0 emit a character. Stores to 0x4 emit a decimal number. A store to 0x8 emits the cycle-count report and then halts.
- Output is an ASCII byte stream with valid/ready handshake, for a UART TX or a bench monitor.
- `stall` back-pressures the core while the block cannot accept a store.

Parameters:
- FIFO_DEPTH, 16, output byte FIFO entries; power of two, minimum 4.
- ADDR_CHAR, 32'h0, character port address.
- ADDR_DEC, 32'h4, decimal port address.
- ADDR_HALT, 32'h8, halt/report port address.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- dwaddr  in  `ADDR_LEN  store address
- dwdata  in  `DATA_LEN  store data
- dwe  in  1  store enable
- cycle_cnt  in  32  free-running cycle count, sampled on halt store
- stall  out  1  store to a port address is not accepted this cycle; core holds it
- out_byte  out  8  FIFO head byte
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer accepts out_byte when out_valid&&out_ready
- busy  out  1  FSM not IDLE or FIFO non-empty
- halt  out  1  sticky; set after report fully drained

Behaviour:
- Reset: FSM=IDLE, FIFO empty, stall=0, out_valid=0, out_byte=0, busy=0, halt=0. Reset mid-conversion aborts it and discards FIFO contents.
- Hit: dwe && dwaddr equals a port address; exact 32-bit compare; dwsize ignored.
- Accept: hit && !stall.
- stall = hit && (FSM!=IDLE || FIFO full || halt). Non-hit stores never stall.
- Once halt=1, all hits stall forever.
- Char accept: push dwdata[7:0] on the same edge; FSM stays IDLE.
- Dec accept: latch value=dwdata as unsigned; enter DEC.
- Halt accept: latch value=cycle_cnt; push 8'h0A; enter DEC with report flag set.
- DEC state uses a 10-entry power-of-ten table, index k = 9 down to 0.
  - Each cycle, if value >= 10^k: value -= 10^k and digit++.
  - Otherwise go to DPUSH.
  - At most 9 subtractions per digit; worst case about 110 cycles per number.
- DPUSH state: waits while FIFO full.
  - Pushes ' ' (0x20) if digit==0, no nonzero digit emitted yet, and k!=0.
  - Otherwise pushes '0'+digit.
  - Then clears digit. If k>0, decrements k and returns to DEC.
  - If k==0: goes to STR if report flag is set, else IDLE.
- Output of each number is always exactly 10 chars, right-justified, space-padded, with no sign.
- STR state pushes " clks\n" (20 63 6C 6B 73 0A), one byte per cycle, waiting while FIFO full; then enters DRAIN.
- DRAIN waits for FIFO empty, then sets halt=1 and enters HALTED. Only reset leaves HALTED.
- FIFO ordering and flow:
  - Internal pushes and FIFO pops are the only FIFO traffic; at most one push per cycle.
  - Push and pop in the same cycle are allowed, including when the FIFO is full, provided out_ready=1.
  - Order is strictly first in, first out.
  - out_byte is registered head data, valid the cycle after the push into an empty FIFO.
- Wrap-around: read/write pointers have log2(FIFO_DEPTH)+1 bits. full when MSBs differ and the rest are equal; empty when all bits are equal.
- Data-store behaviour (memory write) is not affected; this block only snoops.

Test Plan:
- Char store dwdata=32'h00000041, out_ready=1 → out_byte=0x41, out_valid for 1 cycle, stall=0 throughout.
- Dec store 42 → stream "        42" (8×0x20, 0x34, 0x32). Dec store 0 → 9 spaces then 0x30. Dec store 32'hFFFFFFFF → "4294967295".
- out_ready=0, 16 char stores → 17th store sees stall=1 and is held. Raise out_ready → 17th accepted; all 17 bytes in order.
- Dec store 1000000000 immediately followed by char store 'X' → 'X' stalls until IDLE and appears after "1000000000".
- Halt store with cycle_cnt=123 → "\n" + "       123" + " clks\n". halt=1 only after the last byte is popped. A later store to 0x0 stalls.
- Reset asserted mid-DEC with 5 bytes queued → next cycle out_valid=0, busy=0. A following char store 'Z' is output alone.

Source files
------------

// File: rtl/mmio_console.sv
// mmio_console: snoops stores on data write port 1 and turns writes to the
// character, decimal and halt/report ports into an ASCII byte stream.
// Decimal values are converted by repeated subtraction of powers of ten and
// always printed as 10 right-justified, space-padded characters. The halt
// store prints the sampled cycle count followed by " clks\n", waits for the
// stream to drain completely and then raises a sticky halt flag.
module mmio_console #(
    parameter int          FIFO_DEPTH = 16,
    parameter logic [31:0] ADDR_CHAR  = 32'h0000_0000,
    parameter logic [31:0] ADDR_DEC   = 32'h0000_0004,
    parameter logic [31:0] ADDR_HALT  = 32'h0000_0008
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_dwaddr,
    input  logic [31:0] i_dwdata,
    input  logic        i_dwe,
    input  logic [31:0] i_cycle_cnt,
    output logic        o_stall,
    output logic [7:0]  o_out_byte,
    output logic        o_out_valid,
    input  logic        i_out_ready,
    output logic        o_busy,
    output logic        o_halt
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DEC,
        S_DPUSH,
        S_STR,
        S_DRAIN,
        S_HALTED
    } state_t;

    // Powers of ten used by the subtract-and-count conversion; k = 9 is the
    // most significant position a 32-bit unsigned value can occupy.
    function automatic logic [31:0] pow10(input logic [3:0] k);
        logic [31:0] p;
        case (k)
            4'd0:    p = 32'd1;
            4'd1:    p = 32'd10;
            4'd2:    p = 32'd100;
            4'd3:    p = 32'd1000;
            4'd4:    p = 32'd10000;
            4'd5:    p = 32'd100000;
            4'd6:    p = 32'd1000000;
            4'd7:    p = 32'd10000000;
            4'd8:    p = 32'd100000000;
            4'd9:    p = 32'd1000000000;
            default: p = 32'd0;
        endcase
        return p;
    endfunction

    // Suffix appended after the cycle-count report: " clks\n".
    function automatic logic [7:0] clks_char(input logic [2:0] idx);
        logic [7:0] c;
        case (idx)
            3'd0:    c = 8'h20;
            3'd1:    c = 8'h63;
            3'd2:    c = 8'h6C;
            3'd3:    c = 8'h6B;
            3'd4:    c = 8'h73;
            3'd5:    c = 8'h0A;
            default: c = 8'h00;
        endcase
        return c;
    endfunction

    // FSM and conversion registers
    state_t      r_state;
    logic [31:0] r_value;
    logic [3:0]  r_k;
    logic [3:0]  r_digit;
    logic        r_seen;
    logic        r_report;
    logic [2:0]  r_str_idx;
    logic        r_halt;

    // FIFO storage, pointers (one extra wrap bit) and registered head byte
    logic [7:0]  r_mem [FIFO_DEPTH];
    logic [AW:0] r_wptr;
    logic [AW:0] r_rptr;
    logic [7:0]  r_out_byte;

    // Combinational next values and handshake terms
    state_t      w_state_next;
    logic [31:0] w_value_next;
    logic [3:0]  w_k_next;
    logic [3:0]  w_digit_next;
    logic        w_seen_next;
    logic        w_report_next;
    logic [2:0]  w_str_idx_next;
    logic        w_halt_next;

    logic        w_hit;
    logic        w_accept;
    logic        w_empty;
    logic        w_full;
    logic        w_pop;
    logic        w_push;
    logic [7:0]  w_push_data;
    logic        w_can_push;
    logic [31:0] w_pow;
    logic [AW:0] w_wptr_next;
    logic [AW:0] w_rptr_next;
    logic [7:0]  w_head_next;

    // Address decode, FIFO status and the back-pressure seen by the core.
    // The core is only ever stalled on stores that hit one of our ports.
    always_comb begin
        w_hit      = i_dwe && ((i_dwaddr == ADDR_CHAR) ||
                               (i_dwaddr == ADDR_DEC)  ||
                               (i_dwaddr == ADDR_HALT));
        w_empty    = (r_wptr == r_rptr);
        w_full     = (r_wptr[AW] != r_rptr[AW]) &&
                     (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
        w_pop      = !w_empty && i_out_ready;
        w_can_push = !w_full || w_pop;
        w_stall_calc();
        w_accept   = w_hit && !o_stall;
        w_pow      = pow10(r_k);
    end

    function automatic void w_stall_calc();
        o_stall = w_hit && ((r_state != S_IDLE) || w_full || r_halt);
    endfunction

    // Next-state logic: decodes accepted stores in IDLE, runs the digit
    // conversion, emits the report suffix and waits for the drain before halt.
    always_comb begin
        w_state_next   = r_state;
        w_value_next   = r_value;
        w_k_next       = r_k;
        w_digit_next   = r_digit;
        w_seen_next    = r_seen;
        w_report_next  = r_report;
        w_str_idx_next = r_str_idx;
        w_halt_next    = r_halt;
        w_push         = 1'b0;
        w_push_data    = 8'h00;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (i_dwaddr == ADDR_CHAR) begin
                        w_push      = 1'b1;
                        w_push_data = i_dwdata[7:0];
                    end else if (i_dwaddr == ADDR_DEC) begin
                        w_value_next  = i_dwdata;
                        w_k_next      = 4'd9;
                        w_digit_next  = 4'd0;
                        w_seen_next   = 1'b0;
                        w_report_next = 1'b0;
                        w_state_next  = S_DEC;
                    end else begin
                        w_push        = 1'b1;
                        w_push_data   = 8'h0A;
                        w_value_next  = i_cycle_cnt;
                        w_k_next      = 4'd9;
                        w_digit_next  = 4'd0;
                        w_seen_next   = 1'b0;
                        w_report_next = 1'b1;
                        w_state_next  = S_DEC;
                    end
                end
            end

            S_DEC: begin
                if (r_value >= w_pow) begin
                    w_value_next = r_value - w_pow;
                    w_digit_next = r_digit + 4'd1;
                end else begin
                    w_state_next = S_DPUSH;
                end
            end

            S_DPUSH: begin
                if (w_can_push) begin
                    w_push = 1'b1;
                    if ((r_digit == 4'd0) && !r_seen && (r_k != 4'd0)) begin
                        w_push_data = 8'h20;
                    end else begin
                        w_push_data = {4'h3, r_digit};
                    end
                    if (r_digit != 4'd0) begin
                        w_seen_next = 1'b1;
                    end
                    w_digit_next = 4'd0;
                    if (r_k != 4'd0) begin
                        w_k_next     = r_k - 4'd1;
                        w_state_next = S_DEC;
                    end else if (r_report) begin
                        w_str_idx_next = 3'd0;
                        w_state_next   = S_STR;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end

            S_STR: begin
                if (w_can_push) begin
                    w_push      = 1'b1;
                    w_push_data = clks_char(r_str_idx);
                    if (r_str_idx == 3'd5) begin
                        w_state_next = S_DRAIN;
                    end else begin
                        w_str_idx_next = r_str_idx + 3'd1;
                    end
                end
            end

            S_DRAIN: begin
                if (w_empty) begin
                    w_halt_next  = 1'b1;
                    w_state_next = S_HALTED;
                end
            end

            S_HALTED: begin
                w_state_next = S_HALTED;
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // FSM state register; reset aborts any conversion in progress.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= S_IDLE;
            r_value   <= 32'd0;
            r_k       <= 4'd0;
            r_digit   <= 4'd0;
            r_seen    <= 1'b0;
            r_report  <= 1'b0;
            r_str_idx <= 3'd0;
            r_halt    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_value   <= w_value_next;
            r_k       <= w_k_next;
            r_digit   <= w_digit_next;
            r_seen    <= w_seen_next;
            r_report  <= w_report_next;
            r_str_idx <= w_str_idx_next;
            r_halt    <= w_halt_next;
        end
    end

    // Next FIFO pointers and the byte that will sit at the head after this
    // edge. When the new head slot is the one being written right now, the
    // push data is forwarded so out_byte is valid together with out_valid.
    always_comb begin
        w_wptr_next = r_wptr + {{AW{1'b0}}, w_push};
        w_rptr_next = r_rptr + {{AW{1'b0}}, w_pop};
        if (w_rptr_next == w_wptr_next) begin
            w_head_next = r_out_byte;
        end else if (w_rptr_next == r_wptr) begin
            w_head_next = w_push_data;
        end else begin
            w_head_next = r_mem[w_rptr_next[AW-1:0]];
        end
    end

    // FIFO pointers and registered head byte; reset discards all contents.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_out_byte <= 8'h00;
        end else begin
            r_wptr     <= w_wptr_next;
            r_rptr     <= w_rptr_next;
            r_out_byte <= w_head_next;
        end
    end

    // FIFO storage array; pushes are already gated so a full FIFO is never
    // overwritten unless the head is popped on the same edge.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wptr[AW-1:0]] <= w_push_data;
        end
    end

    assign o_out_byte  = r_out_byte;
    assign o_out_valid = !w_empty;
    assign o_busy      = (r_state != S_IDLE) || !w_empty;
    assign o_halt      = r_halt;

endmodule
